// File: rtl/voice_mixer_pkg.sv
// Shared types and helpers for the voice mixer.
//   gain_t         : unsigned Q1.7 per-voice gain, 8'h80 = 1.0
//   GAIN_UNITY     : gain value for unity
//   GAIN_FRAC_BITS : fractional bits in gain_t
//   saturate()     : clamps a signed value to the signed range of a given width
package voice_mixer_pkg;

    typedef logic [7:0] gain_t;

    localparam gain_t       GAIN_UNITY     = 8'h80;
    localparam int unsigned GAIN_FRAC_BITS = 7;
    localparam int unsigned SAT_W          = 64;

    // Clamp v into [-2^(w-1), 2^(w-1)-1]; w must be between 2 and SAT_W-1.
    function automatic logic signed [SAT_W-1:0] saturate(
        input logic signed [SAT_W-1:0] v,
        input int unsigned             w
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/voice_mixer_if.sv
// Subsample / gain-write / output bus of the voice mixer.
//   slave  : the mixer (consumes subsamples and gain writes, drives the sample port)
//   master : the upstream pipeline plus downstream consumer seen as one agent
interface voice_mixer_if
    import voice_mixer_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned OUT_WIDTH    = 16,
    parameter int unsigned NUM_VOICES   = 32,
    parameter int unsigned SHIFT_WIDTH  = 4
);
    localparam int unsigned VOICE_W = $clog2(NUM_VOICES);

    logic                           i_SubsampleValid;
    logic signed [SAMPLE_WIDTH-1:0] i_Subsample;
    logic [VOICE_W-1:0]             i_SubsampleVoice;
    logic                           i_SubsampleLast;
    logic                           i_GainWriteEnable;
    logic [VOICE_W-1:0]             i_GainWriteAddr;
    gain_t                          i_GainWriteData;
    logic [SHIFT_WIDTH-1:0]         i_MasterShift;
    logic signed [OUT_WIDTH-1:0]    o_Sample;
    logic                           o_SampleValid;
    logic                           i_SampleReady;
    logic                           o_SampleClipped;
    logic                           o_FrameDropped;
    logic                           o_FrameError;

    modport slave (
        input  i_SubsampleValid, i_Subsample, i_SubsampleVoice, i_SubsampleLast,
        input  i_GainWriteEnable, i_GainWriteAddr, i_GainWriteData, i_MasterShift,
        input  i_SampleReady,
        output o_Sample, o_SampleValid, o_SampleClipped, o_FrameDropped, o_FrameError
    );

    modport master (
        output i_SubsampleValid, i_Subsample, i_SubsampleVoice, i_SubsampleLast,
        output i_GainWriteEnable, i_GainWriteAddr, i_GainWriteData, i_MasterShift,
        output i_SampleReady,
        input  o_Sample, o_SampleValid, o_SampleClipped, o_FrameDropped, o_FrameError
    );

endinterface

// File: rtl/voice_mixer_gain_ram.sv
// Per-voice gain store: DEPTH x 8 synchronous read-first RAM, no reset.
//   clk     : clock
//   we_i    : write strobe
//   waddr_i : write address
//   wdata_i : write data (Q1.7 gain)
//   raddr_i : read address, data appears after the next edge
//   rdata_o : registered read data (old contents on a same-address write)
module mixer_gain_ram
    import voice_mixer_pkg::*;
#(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  gain_t             wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output gain_t             rdata_o
);

    gain_t mem_q [DEPTH];

    // Read and write in one block so a colliding read returns the pre-write value.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/voice_mixer.sv
// Frame mixer: gain-scales one subsample per voice, accumulates the frame,
// applies a master arithmetic right shift, saturates and holds the result for
// a valid/ready consumer.
//   i_Clock   : clock, rising edge
//   i_Reset_n : asynchronous active-low reset (release synchronised internally)
//   bus       : voice_mixer_if.slave (subsample in, gain write, shift, sample out)
module voice_mixer
    import voice_mixer_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned OUT_WIDTH    = 16,
    parameter int unsigned NUM_VOICES   = 32,
    parameter int unsigned SHIFT_WIDTH  = 4
) (
    input  logic          i_Clock,
    input  logic          i_Reset_n,
    voice_mixer_if.slave  bus
);

    localparam int unsigned VOICE_W  = $clog2(NUM_VOICES);
    localparam int unsigned CNT_W    = VOICE_W + 1;
    localparam int unsigned PROD_W   = SAMPLE_WIDTH + 9;
    localparam int unsigned SCALED_W = SAMPLE_WIDTH + 2;
    localparam int unsigned ACC_W    = SCALED_W + VOICE_W;

    // Reset synchroniser: assert immediately, release on the second edge.
    logic [1:0] rst_sync_q;
    logic       rst_n_int;

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync_q[1];

    // Gain lookup is issued with the subsample so it lines up with S1.
    gain_t gain_rd;

    mixer_gain_ram #(
        .DEPTH (NUM_VOICES)
    ) u_gain_ram (
        .clk     (i_Clock),
        .we_i    (bus.i_GainWriteEnable),
        .waddr_i (bus.i_GainWriteAddr),
        .wdata_i (bus.i_GainWriteData),
        .raddr_i (bus.i_SubsampleVoice),
        .rdata_o (gain_rd)
    );

    // Pipeline and output state.
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic                           s1_valid_q, s1_last_q, s1_kill_q;
    logic signed [SAMPLE_WIDTH-1:0] s1_sample_q;
    logic                           s2_valid_q, s2_last_q;
    logic signed [SCALED_W-1:0]     s2_scaled_q, s2_scaled_d;
    logic signed [ACC_W-1:0]        acc_q, acc_d;
    logic signed [OUT_WIDTH-1:0]    sample_q, sample_d;
    logic                           valid_q, valid_d;
    logic                           clip_q, clip_d;
    logic                           drop_q, drop_d;
    logic                           err_q, err_d;

    logic                           cnt_full_c;
    logic signed [PROD_W-1:0]       product_c;
    logic signed [ACC_W-1:0]        total_c, shifted_c;
    logic signed [SAT_W-1:0]        sat_c;
    logic                           clip_c, xfer_c;

    assign cnt_full_c = (cnt_q == CNT_W'(NUM_VOICES));

    // S1: frame counter; an over-length subsample is flagged and zeroed later.
    always_comb begin
        cnt_d = cnt_q;
        err_d = 1'b0;
        if (bus.i_SubsampleValid) begin
            err_d = cnt_full_c;
            if (bus.i_SubsampleLast) begin
                cnt_d = '0;
            end else if (!cnt_full_c) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // S2: signed product with zero-extended gain, drop the Q1.7 fraction.
    assign product_c   = PROD_W'(s1_sample_q) * PROD_W'($signed({1'b0, gain_rd}));
    assign s2_scaled_d = s1_kill_q ? '0 : SCALED_W'(product_c >>> GAIN_FRAC_BITS);

    // S3: frame total, master shift and saturation.
    assign total_c   = acc_q + ACC_W'(s2_scaled_q);
    assign shifted_c = total_c >>> bus.i_MasterShift;
    assign sat_c     = saturate(SAT_W'(shifted_c), OUT_WIDTH);
    assign clip_c    = (sat_c != SAT_W'(shifted_c));
    assign xfer_c    = valid_q && bus.i_SampleReady;

    // Accumulate / close frame and manage the output holding register.
    always_comb begin
        acc_d    = acc_q;
        sample_d = sample_q;
        valid_d  = valid_q;
        clip_d   = clip_q;
        drop_d   = 1'b0;
        if (xfer_c) begin
            valid_d = 1'b0;
        end
        if (s2_valid_q) begin
            if (s2_last_q) begin
                acc_d = '0;
                if (!valid_q || xfer_c) begin
                    sample_d = OUT_WIDTH'(sat_c);
                    clip_d   = clip_c;
                    valid_d  = 1'b1;
                end else begin
                    drop_d = 1'b1;
                end
            end else begin
                acc_d = total_c;
            end
        end
    end

    always_ff @(posedge i_Clock or negedge rst_n_int) begin
        if (!rst_n_int) begin
            cnt_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_kill_q   <= 1'b0;
            s1_sample_q <= '0;
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_scaled_q <= '0;
            acc_q       <= '0;
            sample_q    <= '0;
            valid_q     <= 1'b0;
            clip_q      <= 1'b0;
            drop_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            s1_valid_q  <= bus.i_SubsampleValid;
            s1_last_q   <= bus.i_SubsampleLast;
            s1_kill_q   <= err_d;
            s1_sample_q <= bus.i_Subsample;
            s2_valid_q  <= s1_valid_q;
            s2_last_q   <= s1_last_q;
            s2_scaled_q <= s2_scaled_d;
            acc_q       <= acc_d;
            sample_q    <= sample_d;
            valid_q     <= valid_d;
            clip_q      <= clip_d;
            drop_q      <= drop_d;
            err_q       <= err_d;
        end
    end

    assign bus.o_Sample        = sample_q;
    assign bus.o_SampleValid   = valid_q;
    assign bus.o_SampleClipped = clip_q;
    assign bus.o_FrameDropped  = drop_q;
    assign bus.o_FrameError    = err_q;

endmodule

// File: tb/tb_voice_mixer.sv
// Scoreboard bench for voice_mixer: stimulus pushes expected samples, a
// negedge monitor pops and compares on every output transfer.
module tb_voice_mixer;

    logic clk;
    logic rst_n;

    voice_mixer_if #(
        .SAMPLE_WIDTH (16),
        .OUT_WIDTH    (16),
        .NUM_VOICES   (32),
        .SHIFT_WIDTH  (4)
    ) mix_if ();

    voice_mixer #(
        .SAMPLE_WIDTH (16),
        .OUT_WIDTH    (16),
        .NUM_VOICES   (32),
        .SHIFT_WIDTH  (4)
    ) dut (
        .i_Clock   (clk),
        .i_Reset_n (rst_n),
        .bus       (mix_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int sample;
        bit clip;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   drop_cnt = 0;
    int   err_cnt  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compare each transferred sample and count status pulses.
    always @(negedge clk) begin
        if (mix_if.o_SampleValid && mix_if.i_SampleReady) begin
            if (q.size() == 0) begin
                check("unexpected_sample", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sb_sample", longint'(mix_if.o_Sample), longint'(e.sample));
                check("sb_clipped", longint'(mix_if.o_SampleClipped), longint'(e.clip));
            end
        end
        if (mix_if.o_FrameDropped) drop_cnt++;
        if (mix_if.o_FrameError) err_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int s, input int v, input bit last);
        mix_if.i_SubsampleValid = 1'b1;
        mix_if.i_Subsample      = 16'(s);
        mix_if.i_SubsampleVoice = 5'(v);
        mix_if.i_SubsampleLast  = last;
        tick();
        mix_if.i_SubsampleValid = 1'b0;
        mix_if.i_SubsampleLast  = 1'b0;
    endtask

    task automatic write_gain(input int a, input int g);
        mix_if.i_GainWriteEnable = 1'b1;
        mix_if.i_GainWriteAddr   = 5'(a);
        mix_if.i_GainWriteData   = 8'(g);
        tick();
        mix_if.i_GainWriteEnable = 1'b0;
    endtask

    task automatic write_all(input int g);
        for (int i = 0; i < 32; i++) write_gain(i, g);
    endtask

    task automatic expect_sample(input int s, input bit c);
        exp_t e;
        e.sample = s;
        e.clip   = c;
        q.push_back(e);
    endtask

    // Bounded wait for the scoreboard to empty.
    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        check(name, longint'(q.size()), 0);
        q.delete();
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_sample"}, longint'(mix_if.o_Sample), 0);
        check({name, "_valid"}, longint'(mix_if.o_SampleValid), 0);
        check({name, "_clipped"}, longint'(mix_if.o_SampleClipped), 0);
        check({name, "_dropped"}, longint'(mix_if.o_FrameDropped), 0);
        check({name, "_error"}, longint'(mix_if.o_FrameError), 0);
    endtask

    initial begin
        int d0;
        int e0;

        rst_n                    = 1'b0;
        mix_if.i_SubsampleValid  = 1'b0;
        mix_if.i_Subsample       = '0;
        mix_if.i_SubsampleVoice  = '0;
        mix_if.i_SubsampleLast   = 1'b0;
        mix_if.i_GainWriteEnable = 1'b0;
        mix_if.i_GainWriteAddr   = '0;
        mix_if.i_GainWriteData   = '0;
        mix_if.i_MasterShift     = '0;
        mix_if.i_SampleReady     = 1'b1;
        #1;
        check_idle_outputs("por");
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // 1: reset in the middle of a frame discards the partial sum.
        write_all(8'h80);
        for (int i = 0; i < 5; i++) send(1000, i, 1'b0);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst");
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        expect_sample(10, 1'b0);
        send(10, 0, 1'b1);
        drain("t1_drain");

        // 2: full 32-voice frame, shift 5, latency of the valid.
        mix_if.i_MasterShift = 4'd5;
        expect_sample(100, 1'b0);
        for (int i = 0; i < 32; i++) send(100, i, i == 31);
        check("t2_valid_e0", longint'(mix_if.o_SampleValid), 0);
        tick();
        check("t2_valid_e1", longint'(mix_if.o_SampleValid), 0);
        tick();
        check("t2_valid_e2", longint'(mix_if.o_SampleValid), 1);
        check("t2_sample_e2", longint'(mix_if.o_Sample), 100);
        drain("t2_drain");
        mix_if.i_MasterShift = 4'd0;

        // 3: gain write colliding with the read returns the old gain, then the new.
        expect_sample(-1000, 1'b0);
        expect_sample(-500, 1'b0);
        mix_if.i_GainWriteEnable = 1'b1;
        mix_if.i_GainWriteAddr   = 5'd3;
        mix_if.i_GainWriteData   = 8'h40;
        send(-1000, 3, 1'b1);
        mix_if.i_GainWriteEnable = 1'b0;
        send(-1000, 3, 1'b1);
        drain("t3_drain");

        // 4: positive and negative saturation.
        write_all(8'hFF);
        expect_sample(32767, 1'b1);
        for (int i = 0; i < 32; i++) send(32767, i, i == 31);
        drain("t4_pos_drain");
        expect_sample(-32768, 1'b1);
        for (int i = 0; i < 32; i++) send(-32768, i, i == 31);
        drain("t4_neg_drain");

        // 5: held output with ready low, second frame dropped.
        write_gain(0, 8'h80);
        mix_if.i_SampleReady = 1'b0;
        send(7, 0, 1'b1);
        repeat (4) tick();
        check("t5_valid_held", longint'(mix_if.o_SampleValid), 1);
        check("t5_sample_first", longint'(mix_if.o_Sample), 7);
        d0 = drop_cnt;
        send(9, 0, 1'b1);
        repeat (4) tick();
        check("t5_drop_pulses", longint'(drop_cnt - d0), 1);
        check("t5_sample_kept", longint'(mix_if.o_Sample), 7);
        check("t5_valid_kept", longint'(mix_if.o_SampleValid), 1);
        expect_sample(7, 1'b0);
        mix_if.i_SampleReady = 1'b1;
        tick();
        mix_if.i_SampleReady = 1'b0;
        check("t5_valid_after_xfer", longint'(mix_if.o_SampleValid), 0);
        check("t5_sb_empty", longint'(q.size()), 0);
        mix_if.i_SampleReady = 1'b1;

        // Maximum shift on a negative total floors to -1.
        mix_if.i_MasterShift = 4'd15;
        expect_sample(-1, 1'b0);
        send(-1000, 0, 1'b1);
        drain("shift15_drain");
        mix_if.i_MasterShift = 4'd0;

        // 6: over-length frame flags an error and ignores the extra subsample.
        write_all(8'h80);
        e0 = err_cnt;
        expect_sample(32, 1'b0);
        for (int i = 0; i < 32; i++) send(1, i, 1'b0);
        check("t6_no_err_at_32", longint'(mix_if.o_FrameError), 0);
        send(1, 0, 1'b1);
        check("t6_err_at_33", longint'(mix_if.o_FrameError), 1);
        tick();
        check("t6_err_pulse_end", longint'(mix_if.o_FrameError), 0);
        drain("t6_drain");
        check("t6_err_count", longint'(err_cnt - e0), 1);
        expect_sample(15, 1'b0);
        for (int i = 0; i < 3; i++) send(5, i, i == 2);
        drain("t6_next_drain");
        check("t6_no_new_err", longint'(err_cnt - e0), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
